fifo_drain_ctrl: RTL and testbench
==================================

Name: fifo_drain_ctrl

Overview:
- Read-side controller for the team's push/pop FIFO.
- Drives the FIFO pop interface (po_en, po_data, empty) on command, draining a programmed number of entries into a downstream valid/ready stream.
- Holds a 2-entry output buffer, flags the final beat of each drain, and pulses done when the command completes.
- Sits between the FIFO and any consumer that needs backpressure or burst framing.

Parameters:
- WIDTH, 10, data width; must match the FIFO's WIDTH.
- DEPTH, 32, FIFO depth.
- LG_DEPTH, 5, log2(DEPTH); cmd_len and pop_count are LG_DEPTH+1 bits wide.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  registered; 1 from the first cycle after any reset cycle onward.
- fifo_empty  in  1  FIFO empty flag.
- fifo_po_en  out  1  pop request to the FIFO.
- fifo_po_data  in  WIDTH  FIFO head data; valid in the same cycle as fifo_po_en (combinational head read).
- cmd_valid  in  1  drain command request.
- cmd_ready  out  1  high in IDLE only.
- cmd_len  in  LG_DEPTH+1  number of entries to drain, 0..2^(LG_DEPTH+1)-1.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  buffer head data.
- out_last  out  1  buffer head is the final beat of the command.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on command completion.
- pop_count  out  LG_DEPTH+1  entries popped for the current command.

Behaviour:
- Reset (rst=1 on a clock edge):
  - Next-cycle values: state IDLE, buffer empty, out_valid=0, out_last=0, fifo_po_en=0, done=0, busy=0, pop_count=0, remaining=0, ready=1.
  - Any entries already popped into the buffer are discarded.
- The rst input has priority over all other inputs.
- FSM IDLE:
  - cmd_ready=1.
  - cmd_valid&&cmd_ready: latch remaining=cmd_len, clear pop_count.
  - Next state: DRAIN if cmd_len!=0, else FLUSH.
- FSM DRAIN:
  - fifo_po_en = !fifo_empty && remaining!=0 && buf_count<2. It depends only on registered state and fifo_empty, never on out_ready.
  - On a pop: write fifo_po_data into the buffer tail with last=(remaining==1), decrement remaining, increment pop_count.
  - When a pop makes remaining 0, next state is FLUSH.
  - An empty FIFO stalls DRAIN indefinitely with no timeout. cmd_len>DEPTH is legal; it waits for refills.
- FSM FLUSH:
  - No pops.
  - When buf_count==0, done=1 for one cycle and state returns to IDLE in the same edge.
  - done is registered, asserted the cycle the FSM re-enters IDLE.
  - Zero-length command: FLUSH → done pulse two cycles after accept, with no beats and no out_last.
- Buffer:
  - 2-entry circular buffer of {data,last}.
  - out_valid = buf_count!=0. out_data/out_last come from the head.
  - A beat transfers when out_valid&&out_ready; the head advances and wraps 1→0.
  - Pop and beat transfer in the same cycle: buf_count unchanged.
  - With out_ready held high, throughput is 1 beat/cycle; buf_count stays ≤1.
- Stability: while out_valid=1 and out_ready=0, out_data and out_last hold.
- Width rules: remaining and pop_count are LG_DEPTH+1 bits, unsigned. pop_count never exceeds cmd_len and does not wrap.
- cmd_valid while busy is ignored (cmd_ready=0); the command is not queued.

Test Plan:
- Reset, FIFO preloaded with 0x001..0x004, cmd_len=4, out_ready=1 → beats 0x001..0x004 on 4 consecutive cycles; out_last only on 0x004; pop_count=4; done pulses once; FSM back to IDLE.
- cmd_len=3 with out_ready=0 for 5 cycles → exactly 2 pops; buffer holds 0x001,0x002; fifo_po_en=0; out_data stable at 0x001. Release out_ready → 0x003 delivered with out_last=1.
- FIFO empty, cmd_len=2 → busy=1, no pops. Push 0x0AA then 0x0BB 10 cycles apart → each popped the cycle it appears; 0x0BB carries out_last; done follows.
- cmd_len=0 → no out_valid; done pulse two cycles after accept; pop_count=0.
- rst asserted mid-DRAIN with 2 entries buffered → next cycle out_valid=0, busy=0, ready=1; fifo_po_en low during and after reset.
- cmd_valid pulsed while busy → ignored; after done, a new cmd_len=1 is accepted and drains one beat with out_last=1.

Source files
------------

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl
// Read-side controller for the push/pop FIFO. On a drain command it pops
// cmd_len entries from the FIFO into a 2-entry output buffer and presents
// them on a valid/ready stream. The final beat of the command is flagged
// with out_last, and done pulses once the buffer has emptied afterwards.
//
// Ports:
//   clk, rst        clock (posedge) and synchronous active-high reset
//   ready           registered, 1 from the first cycle after reset onward
//   fifo_empty      FIFO empty flag
//   fifo_po_en      pop request to the FIFO
//   fifo_po_data    FIFO head data, valid in the same cycle as fifo_po_en
//   cmd_valid       drain command request
//   cmd_ready       command accepted (high only when idle)
//   cmd_len         number of entries to drain
//   out_valid       output buffer non-empty
//   out_ready       downstream accept
//   out_data        buffer head data
//   out_last        buffer head is the final beat of the command
//   busy            a command is in progress
//   done            one-cycle pulse on command completion
//   pop_count       entries popped for the current command
module fifo_drain_ctrl #(
    parameter int WIDTH    = 10,
    parameter int DEPTH    = 32,
    parameter int LG_DEPTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                fifo_empty,
    output logic                fifo_po_en,
    input  logic [WIDTH-1:0]    fifo_po_data,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LG_DEPTH:0]   cmd_len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic [LG_DEPTH:0]   pop_count
);

    localparam int CW = LG_DEPTH + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // The command length field must be able to express a full FIFO.
    if (DEPTH != (1 << LG_DEPTH)) begin : g_depth_check
        $error("fifo_drain_ctrl: DEPTH must equal 2**LG_DEPTH");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [CW-1:0]        remaining_r;
    logic [CW-1:0]        pop_count_r;
    logic [WIDTH-1:0]     buf_data_r [2];
    logic                 buf_last_r [2];
    logic                 head_r;
    logic [1:0]           count_r;
    logic                 done_r;
    logic                 ready_r;
    logic                 pop_s;
    logic                 beat_s;
    logic                 tail_s;
    logic                 accept_s;

    // Pop/beat qualifiers; pop never looks at out_ready, only at registered
    // state, so backpressure cannot create a combinational path to the FIFO.
    always_comb begin
        pop_s    = (state_r == S_DRAIN) && !rst && !fifo_empty &&
                   (remaining_r != CNT_ZERO) && (count_r < 2'd2);
        beat_s   = (count_r != 2'd0) && out_ready;
        accept_s = (state_r == S_IDLE) && cmd_valid;
        tail_s   = head_r ^ count_r[0];
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_s = (cmd_len != CNT_ZERO) ? S_DRAIN : S_FLUSH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (pop_s && (remaining_r == CNT_ONE)) begin
                    state_s = S_FLUSH;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_FLUSH: begin
                if (count_r == 2'd0) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_FLUSH;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register, done pulse and ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            done_r  <= (state_r == S_FLUSH) && (count_r == 2'd0);
            ready_r <= 1'b1;
        end
    end

    // Command bookkeeping: remaining entries and pop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_r <= CNT_ZERO;
            pop_count_r <= CNT_ZERO;
        end else if (accept_s) begin
            remaining_r <= cmd_len;
            pop_count_r <= CNT_ZERO;
        end else if (pop_s) begin
            remaining_r <= remaining_r - CNT_ONE;
            pop_count_r <= pop_count_r + CNT_ONE;
        end else begin
            remaining_r <= remaining_r;
            pop_count_r <= pop_count_r;
        end
    end

    // Output buffer storage; a pop writes the slot just past the live entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data_r[0] <= {WIDTH{1'b0}};
            buf_data_r[1] <= {WIDTH{1'b0}};
            buf_last_r[0] <= 1'b0;
            buf_last_r[1] <= 1'b0;
        end else if (pop_s) begin
            buf_data_r[tail_s] <= fifo_po_data;
            buf_last_r[tail_s] <= (remaining_r == CNT_ONE);
        end else begin
            buf_data_r <= buf_data_r;
            buf_last_r <= buf_last_r;
        end
    end

    // Output buffer head pointer and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (beat_s) begin
                head_r <= ~head_r;
            end else begin
                head_r <= head_r;
            end
            case ({pop_s, beat_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign ready      = ready_r;
    assign fifo_po_en = pop_s;
    assign cmd_ready  = (state_r == S_IDLE);
    assign busy       = (state_r != S_IDLE);
    assign done       = done_r;
    assign pop_count  = pop_count_r;
    assign out_valid  = (count_r != 2'd0);
    assign out_data   = buf_data_r[head_r];
    // A stale last flag may sit in an emptied slot; only a live head counts.
    assign out_last   = (count_r != 2'd0) && buf_last_r[head_r];

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl. The bench models the FIFO,
// drives directed commands, pushes expected beats into a scoreboard queue
// and a negedge monitor compares every accepted beat against it.
module tb_fifo_drain_ctrl;

    localparam int WIDTH    = 10;
    localparam int DEPTH    = 32;
    localparam int LG_DEPTH = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ready;
    logic                fifo_empty;
    logic                fifo_po_en;
    logic [WIDTH-1:0]    fifo_po_data;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [LG_DEPTH:0]   cmd_len = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [WIDTH-1:0]    out_data;
    logic                out_last;
    logic                busy;
    logic                done;
    logic [LG_DEPTH:0]   pop_count;

    fifo_drain_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LG_DEPTH(LG_DEPTH)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .fifo_empty(fifo_empty), .fifo_po_en(fifo_po_en), .fifo_po_data(fifo_po_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .pop_count(pop_count)
    );

    always #5 clk = ~clk;

    // FIFO model with combinational head read.
    logic [WIDTH-1:0] fifo_mem [64];
    int unsigned      rd_ptr = 0;
    int unsigned      wr_ptr = 0;
    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_po_data = fifo_mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (fifo_po_en === 1'b1) rd_ptr <= rd_ptr + 1;
    end

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int beats    = 0;
    int done_cnt = 0;
    int first_beat_cycle = 0;
    int last_beat_cycle  = 0;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;
    beat_t exp_q [$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a beat is taken at the next posedge when valid&&ready at negedge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            beat_t e;
            if (beats == 0) first_beat_cycle = cycle;
            last_beat_cycle = cycle;
            beats++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: got data 0x%0h last %0b expected none",
                         out_data, out_last);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_last !== e.last) begin
                    failures++;
                    $display("FAIL beat: got data 0x%0h last %0b expected data 0x%0h last %0b",
                             out_data, out_last, e.data, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        fifo_mem[wr_ptr[5:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_beat(input logic [WIDTH-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic send_cmd(input int len);
        cmd_len   = (LG_DEPTH+1)'(len);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, (done_cnt > start) ? 1 : 0, 1);
        tick();
        check({name, "_done_once"}, done_cnt - start, 1);
        check({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int b0;
        // Reset state
        rst = 1'b1;
        tick();
        check("rst_po_en_during", int'(fifo_po_en), 0);
        rst = 1'b0;
        check("rst_ready", int'(ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pop_count", int'(pop_count), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);

        // T1: preloaded 1..4, full-throughput drain
        for (int i = 1; i <= 4; i++) push(WIDTH'(i));
        expect_beat(10'h001, 1'b0); expect_beat(10'h002, 1'b0);
        expect_beat(10'h003, 1'b0); expect_beat(10'h004, 1'b1);
        out_ready = 1'b1;
        b0 = beats;
        send_cmd(4);
        wait_done("t1", 20);
        check("t1_beats", beats - b0, 4);
        check("t1_consecutive", last_beat_cycle - first_beat_cycle, 3);
        check("t1_pop_count", int'(pop_count), 4);

        // T2: backpressure holds two entries
        for (int i = 1; i <= 3; i++) push(WIDTH'(i));
        out_ready = 1'b0;
        send_cmd(3);
        repeat (5) tick();
        check("t2_pop_count", int'(pop_count), 2);
        check("t2_po_en", int'(fifo_po_en), 0);
        check("t2_out_valid", int'(out_valid), 1);
        check("t2_out_data", int'(out_data), 10'h001);
        check("t2_out_last", int'(out_last), 0);
        check("t2_fifo_left", int'(wr_ptr - rd_ptr), 1);
        expect_beat(10'h001, 1'b0); expect_beat(10'h002, 1'b0);
        expect_beat(10'h003, 1'b1);
        out_ready = 1'b1;
        wait_done("t2", 20);
        check("t2_pop_count_end", int'(pop_count), 3);

        // T3: empty FIFO stalls, pops as data appears
        send_cmd(2);
        repeat (3) tick();
        check("t3_busy", int'(busy), 1);
        check("t3_no_pop", int'(pop_count), 0);
        expect_beat(10'h0AA, 1'b0); expect_beat(10'h0BB, 1'b1);
        push(10'h0AA);
        #1 check("t3_pop_aa", int'(fifo_po_en), 1);
        repeat (10) tick();
        check("t3_pop_count_mid", int'(pop_count), 1);
        push(10'h0BB);
        #1 check("t3_pop_bb", int'(fifo_po_en), 1);
        wait_done("t3", 20);

        // T4: zero-length command
        b0 = beats;
        send_cmd(0);
        check("t4_busy", int'(busy), 1);
        check("t4_no_done_yet", int'(done), 0);
        tick();
        check("t4_done", int'(done), 1);
        check("t4_pop_count", int'(pop_count), 0);
        tick();
        check("t4_no_beats", beats - b0, 0);

        // T5: reset mid-drain with two entries buffered
        for (int i = 5; i <= 9; i++) push(WIDTH'(i));
        out_ready = 1'b0;
        send_cmd(5);
        repeat (4) tick();
        check("t5_buffered", int'(pop_count), 2);
        rst = 1'b1;
        #1 check("t5_po_en_in_rst", int'(fifo_po_en), 0);
        tick();
        rst = 1'b0;
        check("t5_out_valid", int'(out_valid), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_ready", int'(ready), 1);
        check("t5_po_en_after", int'(fifo_po_en), 0);
        check("t5_pop_count", int'(pop_count), 0);
        rd_ptr = wr_ptr;
        out_ready = 1'b1;
        tick();

        // T6: command while busy is ignored, then a single-beat command
        send_cmd(2);
        cmd_len = 6'd1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("t6_cmd_ready_busy", int'(cmd_ready), 0);
        expect_beat(10'h011, 1'b0); expect_beat(10'h022, 1'b1);
        push(10'h011); push(10'h022);
        wait_done("t6a", 20);
        expect_beat(10'h033, 1'b1);
        push(10'h033);
        b0 = beats;
        send_cmd(1);
        wait_done("t6b", 20);
        check("t6_one_beat", beats - b0, 1);
        check("t6_pop_count", int'(pop_count), 1);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
